// File: rtl/bit_pattern_pkg.sv
// Purpose : shared constants and elaboration-time helpers for the serial pattern recogniser.
// Latency : n/a (constants and constant functions only).
// Backpr. : n/a.
package bit_pattern_pkg;

   localparam int         DEFAULT_PATTERN_LEN = 3;
   localparam logic [2:0] DEFAULT_PATTERN     = 3'b101;

   // Match depths of the default "101" configuration, named for readability.
   typedef enum logic [1:0] {
      S0   = 2'd0,
      S1   = 2'd1,
      S10  = 2'd2,
      S101 = 2'd3
   } dflt_state_e;

   // Bit i of the pattern in arrival order (i = 0 is the MSB, the first bit received).
   function automatic logic pat_bit(input logic [15:0] pattern, input int len, input int i);
      logic [15:0] t;
      t = pattern >> (len - 1 - i);
      return t[0];
   endfunction

   // Next match depth from depth m (< len) after receiving b.
   // The history implied by depth m is the first m pattern bits; append b and
   // find the longest suffix that is also a pattern prefix.
   function automatic int next_match(input logic [15:0] pattern, input int len,
                                     input int m, input logic b);
      int   best;
      logic ok;
      logic sb;
      best = 0;
      for (int k = 1; k <= m + 1; k++) begin
         if (k <= len) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
               sb = ((m + 1 - k + j) < m) ? pat_bit(pattern, len, m + 1 - k + j) : b;
               if (sb != pat_bit(pattern, len, j)) ok = 1'b0;
            end
            if (ok) best = k;
         end
      end
      return best;
   endfunction

   // Longest proper border of the pattern: where an overlapping search resumes after a hit.
   function automatic int border(input logic [15:0] pattern, input int len);
      int   best;
      logic ok;
      best = 0;
      for (int k = 1; k < len; k++) begin
         ok = 1'b1;
         for (int j = 0; j < k; j++) begin
            if (pat_bit(pattern, len, j) != pat_bit(pattern, len, len - k + j)) ok = 1'b0;
         end
         if (ok) best = k;
      end
      return best;
   endfunction

endpackage

// File: rtl/bit_pattern_sm.sv
// Purpose : Moore serial recogniser; flags when the last PATTERN_LEN bits equal PATTERN (MSB first).
// Latency : outp high for the cycle after the edge that sampled the final pattern bit.
// Backpr. : none; one bit consumed every clock, no stall.
//
// Ports:
//   clock  - rising-edge clock
//   nreset - asynchronous active-low reset; discards any partial match
//   inp    - serial data bit
//   outp   - registered match flag
module bit_pattern_sm
   import bit_pattern_pkg::*;
#(
   parameter int                     PATTERN_LEN = DEFAULT_PATTERN_LEN,
   parameter logic [PATTERN_LEN-1:0] PATTERN     = PATTERN_LEN'(DEFAULT_PATTERN),
   parameter bit                     OVERLAP     = 1'b1
) (
   input  logic clock,
   input  logic nreset,
   input  logic inp,
   output logic outp
);

   localparam int MW      = $clog2(PATTERN_LEN + 1);
   localparam int RESTART = OVERLAP ? border(16'(PATTERN), PATTERN_LEN) : 0;

   logic [MW-1:0] m_q;
   logic [MW-1:0] m_nxt;
   logic          outp_q;

   // Transition table built at elaboration: one entry per depth and input bit.
   // A full match behaves like the restart depth (border or empty).
   logic [MW-1:0] tbl0 [PATTERN_LEN+1];
   logic [MW-1:0] tbl1 [PATTERN_LEN+1];

   for (genvar g = 0; g <= PATTERN_LEN; g++) begin : g_tbl
      localparam int EFF = (g == PATTERN_LEN) ? RESTART : g;
      assign tbl0[g] = MW'(next_match(16'(PATTERN), PATTERN_LEN, EFF, 1'b0));
      assign tbl1[g] = MW'(next_match(16'(PATTERN), PATTERN_LEN, EFF, 1'b1));
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         m_q    <= '0;
         outp_q <= 1'b0;
      end else begin
         m_q    <= m_nxt;
         // Registered compare keeps outp glitch-free and equal to (m_q == PATTERN_LEN).
         outp_q <= (m_nxt == MW'(PATTERN_LEN));
      end
   end

   always_comb begin
      m_nxt = '0;
      for (int i = 0; i <= PATTERN_LEN; i++) begin
         if (m_q == MW'(i)) m_nxt = inp ? tbl1[i] : tbl0[i];
      end
   end

   assign outp = outp_q;

endmodule

// File: tb/tb_bit_pattern_sm.sv
module tb_bit_pattern_sm;

   logic       clock;
   logic       nreset;
   logic       inp;
   logic [5:0] outs;

   int checks;
   int passes;

   // Reference configurations, one per DUT instance.
   int          cfg_len [6];
   logic [15:0] cfg_pat [6];
   bit          cfg_ov  [6];

   // Model state: recent bits and count of bits eligible to form a match.
   logic [31:0] sh    [6];
   int          cnt   [6];
   logic        exp_o [6];

   bit_pattern_sm #(.PATTERN_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1))
      d0 (.clock(clock), .nreset(nreset), .inp(inp), .outp(outs[0]));
   bit_pattern_sm #(.PATTERN_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0))
      d1 (.clock(clock), .nreset(nreset), .inp(inp), .outp(outs[1]));
   bit_pattern_sm #(.PATTERN_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1))
      d2 (.clock(clock), .nreset(nreset), .inp(inp), .outp(outs[2]));
   bit_pattern_sm #(.PATTERN_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b0))
      d3 (.clock(clock), .nreset(nreset), .inp(inp), .outp(outs[3]));
   bit_pattern_sm #(.PATTERN_LEN(6), .PATTERN(6'b110110), .OVERLAP(1'b1))
      d4 (.clock(clock), .nreset(nreset), .inp(inp), .outp(outs[4]));
   bit_pattern_sm #(.PATTERN_LEN(1), .PATTERN(1'b0), .OVERLAP(1'b0))
      d5 (.clock(clock), .nreset(nreset), .inp(inp), .outp(outs[5]));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic act, input logic expv);
      checks++;
      if (act === expv) passes++;
      else $display("FAIL %s: got %0b expected %0b at %0t", name, act, expv, $time);
   endtask

   // Model: a match is the last len bits equal to the pattern, counting only bits
   // since reset (and, without overlap, since the previous hit).
   always @(posedge clock or negedge nreset) begin
      logic [31:0] mask;
      if (!nreset) begin
         for (int i = 0; i < 6; i++) begin
            sh[i]    = '0;
            cnt[i]   = 0;
            exp_o[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < 6; i++) begin
            sh[i]  = {sh[i][30:0], inp};
            cnt[i] = cnt[i] + 1;
            mask   = (32'd1 << cfg_len[i]) - 32'd1;
            if (cnt[i] >= cfg_len[i] && (sh[i] & mask) == {16'd0, cfg_pat[i]}) begin
               exp_o[i] = 1'b1;
               if (!cfg_ov[i]) cnt[i] = 0;
            end else begin
               exp_o[i] = 1'b0;
            end
         end
      end
   end

   // Every cycle, mid-period, all instances must agree with the model.
   always @(negedge clock) begin
      for (int i = 0; i < 6; i++) chk($sformatf("model_d%0d", i), outs[i], exp_o[i]);
   end

   task automatic shift(input logic b);
      @(negedge clock);
      inp = b;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clock);
      #2 nreset = 1'b0;
      @(posedge clock);
      #2 nreset = 1'b1;
   endtask

   // Drive n bits MSB first; after each sample compare two instances to literal flags.
   task automatic run_seq(input string name, input int n, input logic [15:0] seq,
                          input int da, input logic [15:0] ea,
                          input int db, input logic [15:0] eb);
      for (int i = 0; i < n; i++) begin
         shift(seq[n-1-i]);
         chk($sformatf("%s_d%0d_s%0d", name, da, i + 1), outs[da], ea[n-1-i]);
         chk($sformatf("%s_d%0d_s%0d", name, db, i + 1), outs[db], eb[n-1-i]);
      end
   endtask

   initial begin
      cfg_len[0] = 3; cfg_pat[0] = 16'b101;    cfg_ov[0] = 1'b1;
      cfg_len[1] = 3; cfg_pat[1] = 16'b101;    cfg_ov[1] = 1'b0;
      cfg_len[2] = 4; cfg_pat[2] = 16'b1111;   cfg_ov[2] = 1'b1;
      cfg_len[3] = 4; cfg_pat[3] = 16'b1111;   cfg_ov[3] = 1'b0;
      cfg_len[4] = 6; cfg_pat[4] = 16'b110110; cfg_ov[4] = 1'b1;
      cfg_len[5] = 1; cfg_pat[5] = 16'b0;      cfg_ov[5] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         sh[i] = '0; cnt[i] = 0; exp_o[i] = 1'b0;
      end
      checks = 0;
      passes = 0;
      inp    = 1'b0;
      nreset = 1'b0;

      // Reset hold with inp low, then zeros keep every non-zero pattern idle.
      @(posedge clock);
      #1;
      for (int i = 0; i < 6; i++) chk($sformatf("rst_hold_d%0d", i), outs[i], 1'b0);
      #1 nreset = 1'b1;
      run_seq("zeros", 4, 16'b0000, 0, 16'b0000, 2, 16'b0000);

      do_reset();
      run_seq("detect", 4, 16'b1010, 0, 16'b0010, 1, 16'b0010);

      do_reset();
      run_seq("overlap", 5, 16'b10101, 0, 16'b00101, 1, 16'b00100);

      do_reset();
      run_seq("nearmiss", 9, 16'b110011101, 0, 16'b000000001, 1, 16'b000000001);

      do_reset();
      run_seq("ones", 6, 16'b111111, 2, 16'b000111, 3, 16'b000100);

      // Asynchronous clear while the flag is up.
      do_reset();
      run_seq("pre_clr", 3, 16'b101, 0, 16'b001, 1, 16'b001);
      #1 nreset = 1'b0;
      #1;
      chk("async_clear_d0", outs[0], 1'b0);
      chk("async_clear_d1", outs[1], 1'b0);
      #1 nreset = 1'b1;

      // Partial progress is lost across a short reset pulse.
      run_seq("partial", 2, 16'b10, 0, 16'b00, 1, 16'b00);
      #1 nreset = 1'b0;
      #2 nreset = 1'b1;
      run_seq("after_pulse", 1, 16'b1, 0, 16'b0, 1, 16'b0);

      // Random traffic with occasional asynchronous reset pulses.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clock);
         inp = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 199) == 0) begin
            @(posedge clock);
            #2 nreset = 1'b0;
            #1 nreset = 1'b1;
         end
      end

      @(negedge clock);
      @(negedge clock);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
